demux_feeder: RTL and testbench
===============================

// Module: demux_feeder
// PURPOSE
//   Upstream driver for the 1x4 demultiplexer stage.
//   - Accepts a 4-bit word on a start pulse.
//   - Serialises it onto a single data line, one bit per channel, lowest channel first.
//   - Steps the 2-bit channel select in lock-step with the data line.
//   - dout/sel wire directly to the demux data input and select.
//   - Provides a start/busy/done handshake to the controlling logic.
// PARAMETERS
//   HOLD_CYCLES  1  clock cycles each channel (sel value) is held; legal range >= 1
// PORTS
//   clk    input   1  system clock; all state updates on rising edge
//   rst    input   1  synchronous, active-high reset
//   start  input   1  request to send; sampled only in IDLE
//   data   input   4  word to distribute; data[k] goes to channel k
//   dout   output  1  serial bit to demux data input
//   sel    output  2  channel select to demux select input
//   busy   output  1  high while a word is being distributed
//   done   output  1  one-cycle pulse after the last channel completes
// BEHAVIOUR
//   Clock and reset
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - Reset values (all registered outputs): state=IDLE, dout=0, sel=2'b00, busy=0, done=0;
//     word register = 0; hold counter = 0; channel index = 0.
//   - rst has priority over every other input, including start in the same cycle.
//   FSM: IDLE -> SEND -> DONE -> IDLE
//   - IDLE
//     - dout=0, sel=00, busy=0, done=0.
//     - start=1 at an edge: latch data into the word register, go to SEND.
//   - SEND
//     - busy=1; sel=channel index; dout=word[index].
//     - First SEND cycle (the cycle after start is sampled): sel=00, dout=data[0].
//     - Each index is held exactly HOLD_CYCLES cycles; the hold counter counts 0..HOLD_CYCLES-1.
//     - Index advances 0->1->2->3 with no wrap. After index 3's final hold cycle, go to DONE.
//   - DONE
//     - Lasts exactly one cycle: done=1, busy=0, dout=0, sel=00. Then go to IDLE.
//   Latency and throughput
//   - start edge to first valid dout: 1 cycle.
//   - busy high for 4*HOLD_CYCLES cycles.
//   - done asserts 4*HOLD_CYCLES+1 cycles after the start edge.
//   - Minimum start-to-start spacing: 4*HOLD_CYCLES+2 cycles.
//   Boundary rules
//   - start while busy, or during the DONE cycle: ignored, not queued.
//   - data changes during SEND: no effect; the latched word is used.
//   - start held high continuously: a new word is taken on each IDLE cycle, i.e. back-to-back
//     words separated by the DONE cycle and one IDLE cycle.
//   - rst asserted mid-SEND: the next cycle shows reset values; the partial word is discarded
//     and done is NOT pulsed.
//   - Outside SEND, dout is forced to 0, so every demux output reads 0 when idle.
//   - Counter widths: index is 2 bits; hold counter is $clog2(HOLD_CYCLES+1) bits.
//     Neither counter wraps beyond its terminal count.
// TESTING
//   1. Reset check: rst=1 for 2 cycles with start=1, data=4'hF
//      -> dout=0, sel=00, busy=0, done=0 throughout; no SEND entered.
//   2. HOLD_CYCLES=1, data=4'b1010, start pulse
//      -> sel 00,01,10,11 on cycles 1-4 with dout 0,1,0,1; busy=1 on cycles 1-4;
//         done=1 on cycle 5 only.
//   3. HOLD_CYCLES=3, data=4'b0110
//      -> each sel value held 3 cycles; dout pattern 000 111 111 000; done on cycle 13.
//   4. start re-pulsed on cycle 2 of a transfer, and data changed to 4'h0 mid-SEND
//      -> original word completes unchanged; exactly one done pulse; no second transfer.
//   5. rst on the 3rd SEND cycle (HOLD_CYCLES=1, data=4'hF)
//      -> next cycle all outputs at reset values; no done pulse; a new start afterwards
//         runs a full transfer from sel=00.
//   6. Chained with the demux, start held high, data=4'b0001 then 4'b1000
//      -> o1 pulses for the first word, then o4 pulses for the second;
//         the words are separated by 2 cycles of all-zero outputs.

Source files
------------

// File: rtl/demux_feeder.sv
// Serialises a 4-bit word onto one data line, lowest channel first, driving a
// 1x4 demux select in lock-step, with a start/busy/done handshake.

module demux_feeder #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data,
  output logic       dout,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       word_q, word_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [1:0]       idx_q, idx_d;
  logic             dout_q, dout_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       idx_inc;

  assign idx_inc = idx_q + 2'd1;

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    dout_d  = 1'b0;
    sel_d   = 2'b00;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d  = data;
          hold_d  = '0;
          idx_d   = 2'd0;
          state_d = StSend;
          busy_d  = 1'b1;
          dout_d  = data[0];
        end
      end

      StSend: begin
        busy_d = 1'b1;
        sel_d  = idx_q;
        dout_d = word_q[idx_q];
        if (hold_q == HoldLast) begin
          hold_d = '0;
          if (idx_q == 2'd3) begin
            state_d = StDone;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            sel_d   = 2'b00;
            dout_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            sel_d  = idx_inc;
            dout_d = word_q[idx_inc];
          end
        end else begin
          hold_d = hold_q + HoldOne;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= 4'h0;
      hold_q  <= '0;
      idx_q   <= 2'd0;
      dout_q  <= 1'b0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout = dout_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_feeder.sv
// Bench for demux_feeder: two instances (hold 1 and hold 3) on shared stimulus,
// each checked cycle by cycle against a schedule-based reference model.

module tb_demux_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] data;

  logic       dout1, busy1, done1;
  logic [1:0] sel1;
  logic       dout3, busy3, done3;
  logic [1:0] sel3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_feeder #(.HOLD_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .dout  (dout1),
    .sel   (sel1),
    .busy  (busy1),
    .done  (done1)
  );

  demux_feeder #(.HOLD_CYCLES(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .dout  (dout3),
    .sel   (sel3),
    .busy  (busy3),
    .done  (done3)
  );

  // Observed vectors: {busy, done, sel, dout}
  logic [4:0] v1, v3;
  logic [3:0] demux1;
  assign v1 = {busy1, done1, sel1, dout1};
  assign v3 = {busy3, done3, sel3, dout3};
  assign demux1 = dout1 ? (4'b0001 << sel1) : 4'b0000;

  // Reference model: t = cycles since the accepted start (0 = idle).
  // Cycles 1..4H send channel (t-1)/H, cycle 4H+1 is the done cycle.
  int         t1 = 0;
  int         t3 = 0;
  logic [3:0] w1 = 4'h0;
  logic [3:0] w3 = 4'h0;

  function automatic int next_t(int t, int h, logic s, logic r);
    if (r) return 0;
    if (t == 0) return s ? 1 : 0;
    if (t >= 4 * h + 1) return 0;
    return t + 1;
  endfunction

  function automatic logic [4:0] exp_vec(int t, logic [3:0] w, int h);
    int k;
    if (t >= 1 && t <= 4 * h) begin
      k = (t - 1) / h;
      return {1'b1, 1'b0, 2'(k), w[k]};
    end
    if (t == 4 * h + 1) return 5'b01000;
    return 5'b00000;
  endfunction

  function automatic logic [3:0] exp_demux(logic [4:0] e);
    return e[0] ? (4'b0001 << e[2:1]) : 4'b0000;
  endfunction

  always @(posedge clk) begin
    t1 <= next_t(t1, 1, start, rst);
    t3 <= next_t(t3, 3, start, rst);
    if (!rst && t1 == 0 && start) w1 <= data;
    if (!rst && t3 == 0 && start) w3 <= data;
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; data = 4'hF;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (v1 !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_h1 c%0d: dut=%b want=%b", c, v1, 5'b00000);
      end
      n_cmp++;
      if (v3 !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_h3 c%0d: dut=%b want=%b", c, v3, 5'b00000);
      end
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (v1 !== 5'b00000 || v3 !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_nosend: h1=%b h3=%b want=00000", v1, v3);
    end
  endtask

  task automatic test_hold1();
    int done_cyc = -1;
    data = 4'b1010; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (v1 !== exp_vec(t1, w1, 1)) begin
        n_err++;
        $display("FAIL hold1 c%0d: dut=%b model=%b", c, v1, exp_vec(t1, w1, 1));
      end
      if (done1 && done_cyc < 0) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 5) begin
      n_err++;
      $display("FAIL hold1_done_cycle: got %0d want 5", done_cyc);
    end
  endtask

  task automatic test_hold3();
    int done_cyc = -1;
    data = 4'b0110; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (v3 !== exp_vec(t3, w3, 3)) begin
        n_err++;
        $display("FAIL hold3 c%0d: dut=%b model=%b", c, v3, exp_vec(t3, w3, 3));
      end
      if (done3 && done_cyc < 0) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 13) begin
      n_err++;
      $display("FAIL hold3_done_cycle: got %0d want 13", done_cyc);
    end
  endtask

  task automatic test_restart_ignored();
    int dones1 = 0;
    int dones3 = 0;
    data = 4'b1101; start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) data = 4'h0;
      n_cmp++;
      if (v1 !== exp_vec(t1, w1, 1)) begin
        n_err++;
        $display("FAIL restart_h1 c%0d: dut=%b model=%b", c, v1, exp_vec(t1, w1, 1));
      end
      n_cmp++;
      if (v3 !== exp_vec(t3, w3, 3)) begin
        n_err++;
        $display("FAIL restart_h3 c%0d: dut=%b model=%b", c, v3, exp_vec(t3, w3, 3));
      end
      if (done1) dones1++;
      if (done3) dones3++;
    end
    n_cmp++;
    if (dones1 != 1 || dones3 != 1) begin
      n_err++;
      $display("FAIL restart_done_count: h1=%0d h3=%0d want 1/1", dones1, dones3);
    end
  endtask

  task automatic test_rst_mid();
    int dones = 0;
    int done_cyc = -1;
    data = 4'hF; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c == 3);
      n_cmp++;
      if (v1 !== exp_vec(t1, w1, 1)) begin
        n_err++;
        $display("FAIL rstmid_h1 c%0d: dut=%b model=%b", c, v1, exp_vec(t1, w1, 1));
      end
      if (c == 4) begin
        n_cmp++;
        if (v1 !== 5'b00000 || v3 !== 5'b00000) begin
          n_err++;
          $display("FAIL rstmid_values: h1=%b h3=%b want 00000", v1, v3);
        end
      end
      if (c >= 4 && (done1 || done3)) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done: got %0d done cycles want 0", dones);
    end
    data = 4'b0101; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (v1 !== exp_vec(t1, w1, 1)) begin
        n_err++;
        $display("FAIL rstmid_rerun c%0d: dut=%b model=%b", c, v1, exp_vec(t1, w1, 1));
      end
      if (c == 1) begin
        n_cmp++;
        if (sel1 !== 2'b00 || busy1 !== 1'b1) begin
          n_err++;
          $display("FAIL rstmid_rerun_first: sel=%b busy=%b want 00/1", sel1, busy1);
        end
      end
      if (done1 && done_cyc < 0) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 5) begin
      n_err++;
      $display("FAIL rstmid_rerun_done: got %0d want 5", done_cyc);
    end
  endtask

  task automatic test_chained();
    int first_o1 = -1;
    int first_o4 = -1;
    data = 4'b0001; start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 2) data = 4'b1000;
      n_cmp++;
      if (demux1 !== exp_demux(exp_vec(t1, w1, 1))) begin
        n_err++;
        $display("FAIL chained c%0d: demux=%b model=%b", c, demux1,
                 exp_demux(exp_vec(t1, w1, 1)));
      end
      if (demux1[0] && first_o1 < 0) first_o1 = c;
      if (demux1[3] && first_o4 < 0) first_o4 = c;
    end
    start = 1'b0;
    // Word 2 starts 4H+2 cycles after word 1; channel 3 is 3H cycles into it.
    n_cmp++;
    if (first_o1 != 1 || first_o4 != 1 + (4 * 1 + 2) + 3 * 1) begin
      n_err++;
      $display("FAIL chained_order: o1@%0d o4@%0d want o1@1 o4@10", first_o1, first_o4);
    end
    idle_cycles(16);
  endtask

  task automatic test_random();
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      n_cmp++;
      if (v1 !== exp_vec(t1, w1, 1)) begin
        n_err++;
        $display("FAIL random_h1 c%0d: dut=%b model=%b", c, v1, exp_vec(t1, w1, 1));
      end
      n_cmp++;
      if (v3 !== exp_vec(t3, w3, 3)) begin
        n_err++;
        $display("FAIL random_h3 c%0d: dut=%b model=%b", c, v3, exp_vec(t3, w3, 3));
      end
      start = ($urandom_range(0, 3) == 0);
      data  = 4'($urandom);
      rst   = ($urandom_range(0, 49) == 0);
    end
    rst = 1'b0;
    start = 1'b0;
    idle_cycles(16);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    data = 4'h0;
    test_reset();
    idle_cycles(2);
    test_hold1();
    test_hold3();
    idle_cycles(2);
    test_restart_ignored();
    test_rst_mid();
    idle_cycles(16);
    test_chained();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
